// File: rtl/cv32e40p_tb_run_ctrl.sv
// Run controller for the cv32e40p test subsystem.
// Sequences the core reset release and fetch enable, counts RUN cycles,
// enforces an optional cycle budget, and latches the run verdict.
//
// exit_valid_i is a one-cycle qualifier with no back-pressure. exit_value_i
// is only meaningful in a cycle where exit_valid_i is high, and it is only
// looked at in RUN. There is no ready; the strobe is consumed on the edge
// that samples it.
module cv32e40p_tb_run_ctrl #(
    parameter int unsigned RESET_WAIT_CYCLES = 4,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [CNT_WIDTH-1:0] max_cycles_i,
    input  logic                 tests_passed_i,
    input  logic                 tests_failed_i,
    input  logic                 exit_valid_i,
    input  logic [31:0]          exit_value_i,
    output logic                 core_rst_no,
    output logic                 fetch_enable_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           status_o,
    output logic [31:0]          exit_code_o,
    output logic [CNT_WIDTH-1:0] cycle_cnt_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] V_NONE     = 3'd0;
    localparam logic [2:0] V_PASS     = 3'd1;
    localparam logic [2:0] V_FAIL     = 3'd2;
    localparam logic [2:0] V_EXIT_OK  = 3'd3;
    localparam logic [2:0] V_EXIT_ERR = 3'd4;
    localparam logic [2:0] V_TIMEOUT  = 3'd5;
    localparam logic [2:0] V_ABORT    = 3'd6;

    localparam int unsigned RW = (RESET_WAIT_CYCLES > 1) ? $clog2(RESET_WAIT_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST = RW'(RESET_WAIT_CYCLES - 1);

    state_e                 state_q;
    logic [RW-1:0]          rst_cnt_q;
    logic [2:0]             status_q;
    logic [31:0]            exit_code_q;
    logic [CNT_WIDTH-1:0]   cycle_cnt_q;

    logic [CNT_WIDTH-1:0]   cycle_cnt_d;
    logic [CNT_WIDTH-1:0]   max_m1;
    logic                   run_end;
    logic [2:0]             run_status_d;

    // RUN-cycle verdict: the highest-priority terminating condition wins
    always_comb begin
        cycle_cnt_d  = (cycle_cnt_q == {CNT_WIDTH{1'b1}}) ? cycle_cnt_q : cycle_cnt_q + 1'b1;
        max_m1       = max_cycles_i - CNT_WIDTH'(1);
        run_end      = 1'b1;
        run_status_d = V_NONE;
        if (abort_i) begin
            run_status_d = V_ABORT;
        end else if (tests_failed_i) begin
            run_status_d = V_FAIL;
        end else if (exit_valid_i) begin
            run_status_d = (exit_value_i == 32'd0) ? V_EXIT_OK : V_EXIT_ERR;
        end else if (tests_passed_i) begin
            run_status_d = V_PASS;
        end else if ((max_cycles_i != '0) && (cycle_cnt_q >= max_m1)) begin
            run_status_d = V_TIMEOUT;
        end else begin
            run_end = 1'b0;
        end
    end

    // Run sequencing FSM with registered verdict, exit code and cycle count
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            rst_cnt_q   <= '0;
            status_q    <= V_NONE;
            exit_code_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_RESET;
                        rst_cnt_q   <= '0;
                        status_q    <= V_NONE;
                        exit_code_q <= '0;
                        cycle_cnt_q <= '0;
                    end
                end
                ST_RESET: begin
                    if (abort_i) begin
                        state_q  <= ST_DONE;
                        status_q <= V_ABORT;
                    end else if (rst_cnt_q == RST_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_end) begin
                        state_q  <= ST_DONE;
                        status_q <= run_status_d;
                        if (!abort_i && !tests_failed_i && exit_valid_i) begin
                            exit_code_q <= exit_value_i;
                        end
                    end else begin
                        cycle_cnt_q <= cycle_cnt_d;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Control outputs are pure decodes of the registered state
    assign core_rst_no    = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign fetch_enable_o = (state_q == ST_RUN);
    assign busy_o         = (state_q == ST_RESET) || (state_q == ST_RUN);
    assign done_o         = (state_q == ST_DONE);
    assign status_o       = status_q;
    assign exit_code_o    = exit_code_q;
    assign cycle_cnt_o    = cycle_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_cv32e40p_tb_run_ctrl.sv
// Directed bench for cv32e40p_tb_run_ctrl with a verdict scoreboard.
module tb_cv32e40p_tb_run_ctrl;

  localparam int W = 32;
  localparam int VW = 3 + 32 + W;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic          abort_i;
  logic [W-1:0]  max_cycles_i;
  logic          tests_passed_i;
  logic          tests_failed_i;
  logic          exit_valid_i;
  logic [31:0]   exit_value_i;
  logic          core_rst_no;
  logic          fetch_enable_o;
  logic          busy_o;
  logic          done_o;
  logic [2:0]    status_o;
  logic [31:0]   exit_code_o;
  logic [W-1:0]  cycle_cnt_o;
  logic [1:0]    state_o;

  int total = 0;
  int bad = 0;
  logic [VW-1:0] exp_q[$];

  cv32e40p_tb_run_ctrl #(.RESET_WAIT_CYCLES(4), .CNT_WIDTH(W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .max_cycles_i(max_cycles_i), .tests_passed_i(tests_passed_i),
    .tests_failed_i(tests_failed_i), .exit_valid_i(exit_valid_i),
    .exit_value_i(exit_value_i), .core_rst_no(core_rst_no),
    .fetch_enable_o(fetch_enable_o), .busy_o(busy_o), .done_o(done_o),
    .status_o(status_o), .exit_code_o(exit_code_o), .cycle_cnt_o(cycle_cnt_o),
    .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic clear_flags();
    abort_i = 1'b0;
    tests_passed_i = 1'b0;
    tests_failed_i = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = $urandom_range(1, 255);
  endtask

  // Pulse start and walk through the 4 RESET cycles; ends in RUN cycle 1.
  task automatic start_run(input string tag);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check({tag, "_clr_status"}, status_o, 0);
    check({tag, "_clr_cnt"}, cycle_cnt_o, 0);
    check({tag, "_clr_code"}, exit_code_o, 0);
    check({tag, "_rst_low"}, core_rst_no, 0);
    repeat (4) tick();
    check({tag, "_run"}, {core_rst_no, fetch_enable_o, busy_o}, 3'b111);
  endtask

  task automatic push_exp(input logic [2:0] st, input logic [31:0] code, input logic [W-1:0] cnt);
    exp_q.push_back({st, code, cnt});
  endtask

  // scoreboard: compare the oldest expected verdict against the DONE outputs
  task automatic check_verdict(input string tag);
    logic [VW-1:0] e;
    check({tag, "_done"}, {done_o, fetch_enable_o, busy_o, core_rst_no}, 4'b1001);
    check({tag, "_qsz"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_status"}, status_o, e[VW-1 -: 3]);
      check({tag, "_code"}, exit_code_o, e[W +: 32]);
      check({tag, "_cnt"}, cycle_cnt_o, e[W-1:0]);
    end
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!done_o && n < budget) begin
      tick();
      n++;
    end
    check("wait_done", done_o, 1);
  endtask

  int n;

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    max_cycles_i = '0;
    clear_flags();
    repeat (3) tick();
    rst_i = 1'b0;
    check("rst_outs", {core_rst_no, fetch_enable_o, busy_o, done_o, status_o}, 0);
    check("rst_regs", {exit_code_o, cycle_cnt_o, state_o}, 0);

    // abort in IDLE is ignored
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    repeat (5) tick();
    check("idle_abort", {state_o, busy_o, done_o, status_o}, 0);

    // reset release timing, then exit with nonzero code on RUN cycle 20
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rel_hold", {core_rst_no, fetch_enable_o, busy_o}, 3'b001);
      tick();
    end
    check("rel_run", {core_rst_no, fetch_enable_o, busy_o}, 3'b111);
    check("rel_cnt0", cycle_cnt_o, 0);
    // start in RUN is ignored
    start_i = 1'b1;
    repeat (19) tick();
    start_i = 1'b0;
    check("run_cnt19", cycle_cnt_o, 19);
    exit_valid_i = 1'b1;
    exit_value_i = 32'h2A;
    push_exp(3'd4, 32'h2A, 19);
    tick();
    clear_flags();
    check_verdict("exit_err");
    // flags and abort in DONE do not disturb the verdict
    tests_failed_i = 1'b1;
    abort_i = 1'b1;
    tick();
    clear_flags();
    tick();
    check("done_hold", {done_o, status_o, exit_code_o}, {1'b1, 3'd4, 32'h2A});

    // timeout after exactly 100 RUN cycles
    max_cycles_i = 100;
    start_run("to");
    push_exp(3'd5, 0, 99);
    wait_done(300, n);
    check("to_len", n, 100);
    check_verdict("timeout");

    // unlimited budget, then shrink the budget mid-run
    max_cycles_i = 0;
    start_run("unl");
    repeat (10000) tick();
    check("unl_busy", {busy_o, fetch_enable_o, done_o}, 3'b110);
    check("unl_cnt", cycle_cnt_o, 10000);
    max_cycles_i = 5;
    push_exp(3'd5, 0, 10000);
    tick();
    check_verdict("shrink");
    max_cycles_i = 0;

    // simultaneous flags: FAIL beats EXIT and PASS
    start_run("pri");
    repeat (2) tick();
    tests_failed_i = 1'b1;
    exit_valid_i = 1'b1;
    exit_value_i = 0;
    tests_passed_i = 1'b1;
    push_exp(3'd2, 0, 2);
    tick();
    clear_flags();
    check_verdict("pri_fail");

    // abort beats everything
    start_run("pra");
    tick();
    abort_i = 1'b1;
    tests_failed_i = 1'b1;
    exit_valid_i = 1'b1;
    exit_value_i = 0;
    tests_passed_i = 1'b1;
    push_exp(3'd6, 0, 1);
    tick();
    clear_flags();
    check_verdict("pri_abort");

    // exit with value 0 beats pass
    start_run("eok");
    n = $urandom_range(3, 30);
    repeat (n) tick();
    exit_valid_i = 1'b1;
    exit_value_i = 0;
    tests_passed_i = 1'b1;
    push_exp(3'd3, 0, n);
    tick();
    clear_flags();
    check_verdict("exit_ok");

    // pass alone
    start_run("pas");
    n = $urandom_range(3, 30);
    repeat (n) tick();
    tests_passed_i = 1'b1;
    push_exp(3'd1, 0, n);
    tick();
    clear_flags();
    check_verdict("pass");

    // abort on the 2nd RESET cycle, core reset never released
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("rab_r1", core_rst_no, 0);
    tick();
    check("rab_r2", core_rst_no, 0);
    abort_i = 1'b1;
    tests_passed_i = 1'bx;
    push_exp(3'd6, 0, 0);
    tick();
    clear_flags();
    check_verdict("rst_abort");
    start_run("restart");

    // synchronous reset mid-run with pass raised
    repeat (5) tick();
    tests_passed_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_flags();
    check("mid_rst_outs", {core_rst_no, fetch_enable_o, busy_o, done_o, status_o, state_o}, 0);
    check("mid_rst_regs", {exit_code_o, cycle_cnt_o}, 0);
    tick();
    check("mid_rst_idle", {state_o, status_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_tb_run_ctrl.md
Name: cv32e40p_tb_run_ctrl

Overview:
Run controller for the cv32e40p test subsystem. Sequences core reset release and fetch enable, counts run cycles, enforces a cycle budget, and latches the run verdict from the subsystem's pass/fail/exit signals. It sits between the simulation top and the core/memory subsystem, replacing ad-hoc initial-block reset and watchdog logic with synthesizable, restartable sequencing.

Parameters:
RESET_WAIT_CYCLES, 4, number of cycles the core reset is held asserted after start (>=1)
CNT_WIDTH, 32, width of cycle counter and cycle budget

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  pulse; begin a run from IDLE or DONE
abort_i  in  1  pulse; terminate a run in RESET or RUN
max_cycles_i  in  CNT_WIDTH  cycle budget for RUN; 0 = unlimited
tests_passed_i  in  1  subsystem pass flag
tests_failed_i  in  1  subsystem fail flag
exit_valid_i  in  1  subsystem exit strobe
exit_value_i  in  32  exit code qualified by exit_valid_i
core_rst_no  out  1  core/subsystem reset, active low
fetch_enable_o  out  1  core fetch enable
busy_o  out  1  high in RESET or RUN
done_o  out  1  high in DONE
status_o  out  3  verdict: 0 NONE, 1 PASS, 2 FAIL, 3 EXIT_OK, 4 EXIT_ERR, 5 TIMEOUT, 6 ABORT
exit_code_o  out  32  latched exit_value_i (EXIT_* only, else 0)
cycle_cnt_o  out  CNT_WIDTH  RUN cycles elapsed

Behaviour:
- Synchronous active-high rst_i: state IDLE; core_rst_no=0, fetch_enable_o=0, busy_o=0, done_o=0, status_o=0, exit_code_o=0, cycle_cnt_o=0. Reset mid-run returns to IDLE next edge, verdict discarded.
- All outputs registered or decoded from registered state only; no combinational input-to-output path.
- States: IDLE, RESET, RUN, DONE.
- IDLE: core_rst_no=0, fetch_enable_o=0. start_i -> RESET; clear cycle_cnt_o, status_o, exit_code_o. abort_i ignored.
- RESET: core_rst_no=0, busy_o=1. Internal counter counts RESET_WAIT_CYCLES cycles in RESET, then -> RUN. start_i at cycle t: core_rst_no low at t+1..t+RESET_WAIT_CYCLES, high from t+RESET_WAIT_CYCLES+1.
- RUN: core_rst_no=1, fetch_enable_o=1, busy_o=1. cycle_cnt_o increments by 1 each RUN cycle, saturating at all-ones. First RUN cycle observes cycle_cnt_o=0.
- RUN termination, evaluated each RUN cycle, priority highest first: abort_i -> ABORT; tests_failed_i -> FAIL; exit_valid_i -> EXIT_OK if exit_value_i==0 else EXIT_ERR, exit_code_o<=exit_value_i; tests_passed_i -> PASS; (max_cycles_i!=0 and cycle_cnt_o>=max_cycles_i-1) -> TIMEOUT. Any -> DONE next edge with status_o set; cycle_cnt_o not incremented on the terminating cycle.
- abort_i in RESET -> DONE, status ABORT, core_rst_no stays 0 in that transition cycle.
- Subsystem flags ignored outside RUN (X/garbage during core reset is tolerated).
- DONE: fetch_enable_o=0, core_rst_no=1 (core stalled, state inspectable), done_o=1; status_o, exit_code_o, cycle_cnt_o held. start_i -> RESET with clears as from IDLE. abort_i ignored.
- start_i in RESET or RUN ignored.
- max_cycles_i sampled every RUN cycle; changing it mid-run takes effect immediately.

Test Plan:
- rst_i high 3 cycles, start_i pulse at cycle 10 (RESET_WAIT_CYCLES=4) -> core_rst_no low 11..14, high and fetch_enable_o=1 from 15, busy_o=1 from 11, cycle_cnt_o=0 at 15.
- Run, exit_valid_i=1 with exit_value_i=0x0000002A on 20th RUN cycle -> next edge done_o=1, status_o=4, exit_code_o=0x2A, cycle_cnt_o=19, fetch_enable_o=0.
- max_cycles_i=100, no flags -> status_o=5 after exactly 100 RUN cycles, cycle_cnt_o=99; max_cycles_i=0 for 10000 cycles -> still RUN.
- tests_failed_i, exit_valid_i (value 0) and tests_passed_i asserted same cycle -> status_o=2, exit_code_o=0; abort_i added same cycle -> status_o=6.
- abort_i on 2nd RESET cycle -> DONE, status_o=6, core_rst_no never released before DONE; start_i in DONE -> fresh RESET, status_o=0, cycle_cnt_o=0.
- rst_i asserted mid-RUN with tests_passed_i high -> IDLE next edge, all outputs at reset values, no PASS latched.
